// File: rtl/clk_edge_meter.sv
// Multi-channel edge-rate meter: counts synchronised edges on N_CH async inputs
// over a fixed gate window and latches saturated per-channel counts at window end.

module clk_edge_lane #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic             cmos_clk_24,
  input  logic             I_rst_n,
  input  logic             sig,
  input  logic             primed,
  input  logic             terminal,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist, s, e, at_max, sat;
  logic [CNT_W-1:0]       acc, inc;

  assign s      = sync_q[SYNC_STAGES-1];
  assign e      = primed & ((EDGE_MODE != 0) ? (s ^ hist) : (s & ~hist));
  assign at_max = &acc;
  assign inc    = {{(CNT_W-1){1'b0}}, e};

  always_ff @(posedge cmos_clk_24 or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q <= '0;
      hist   <= 1'b0;
      acc    <= '0;
      sat    <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      hist   <= s;
      if (clear) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (terminal) begin
        // an edge seen in the terminal cycle still belongs to the closing window
        count <= (at_max & e) ? acc : acc + inc;
        ovf   <= sat | (at_max & e);
        acc   <= '0;
        sat   <= 1'b0;
      end else if (at_max & e) begin
        sat <= 1'b1;
      end else begin
        acc <= acc + inc;
      end
    end
  end
endmodule

module clk_edge_meter #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 24_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                  cmos_clk_24,
  input  logic                  I_rst_n,
  input  logic [N_CH-1:0]       I_sig,
  input  logic                  I_clear,
  output logic [N_CH*CNT_W-1:0] O_count,
  output logic [N_CH-1:0]       O_ovf,
  output logic                  O_valid,
  output logic                  O_gate_tgl
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [GW-1:0] G_LAST     = GW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

  logic [GW-1:0]                g;
  logic [PW-1:0]                prime_cnt;
  logic                         primed, terminal;
  logic [N_CH-1:0][CNT_W-1:0]   cnt;

  assign primed   = (prime_cnt == PRIME_DONE);
  assign terminal = (g == G_LAST) & ~I_clear;
  assign O_count  = cnt;

  always_ff @(posedge cmos_clk_24 or negedge I_rst_n) begin
    if (!I_rst_n) begin
      g          <= '0;
      prime_cnt  <= '0;
      O_valid    <= 1'b0;
      O_gate_tgl <= 1'b0;
    end else begin
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
      O_valid <= terminal;
      if (I_clear) begin
        g <= '0;
      end else if (terminal) begin
        g          <= '0;
        O_gate_tgl <= ~O_gate_tgl;
      end else begin
        g <= g + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    clk_edge_lane #(
      .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)
    ) u_lane (
      .cmos_clk_24(cmos_clk_24),
      .I_rst_n    (I_rst_n),
      .sig        (I_sig[i]),
      .primed     (primed),
      .terminal   (terminal),
      .clear      (I_clear),
      .count      (cnt[i]),
      .ovf        (O_ovf[i])
    );
  end
endmodule
